// File: rtl/reg_transfer_if.sv
// reg_transfer_if: request/strobe bundle between a transfer requester and reg_transfer_seq.
//   req              requester -> sequencer  transfer request
//   src, dst         requester -> sequencer  source / destination register index
//   busy             sequencer -> requester  transfer in progress
//   done, err        sequencer -> requester  one-cycle completion / rejection pulses
//   assert_main_bar  sequencer -> registers  per-register main-bus drive enable, active low
//   load             sequencer -> registers  per-register load, captured on falling edge
interface reg_transfer_if #(
    parameter int unsigned NumRegs = 4
);
    localparam int unsigned SelW = $clog2(NumRegs);

    logic                req;
    logic [SelW-1:0]     src;
    logic [SelW-1:0]     dst;
    logic                busy;
    logic                done;
    logic                err;
    logic [NumRegs-1:0]  assert_main_bar;
    logic [NumRegs-1:0]  load;

    modport master (
        output req, src, dst,
        input  busy, done, err, assert_main_bar, load
    );

    modport slave (
        input  req, src, dst,
        output busy, done, err, assert_main_bar, load
    );
endinterface

// File: rtl/reg_transfer_seq.sv
// reg_transfer_seq: sequences one SRC -> DST register transfer over the shared main bus.
// The source drives the bus for SettleCycles cycles before the destination LOAD rises and
// keeps driving through LOAD's falling (capture) edge, so nothing captures a floating bus.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  reg_transfer_if slave: req/src/dst in; busy/done/err/assert_main_bar/load out
// All outputs come straight from flops; they are computed from the next state.
module reg_transfer_seq #(
    parameter int unsigned NumRegs      = 4,
    parameter int unsigned SettleCycles = 1,
    // Output edge delays belong to the behavioural model only; this RTL is zero-delay.
    parameter int unsigned DelayRise    = 0,
    parameter int unsigned DelayFall    = 0
) (
    input logic           clk,
    input logic           rst,
    reg_transfer_if.slave bus
);
    localparam int unsigned SelW = $clog2(NumRegs);
    localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

    if (NumRegs < 2 || NumRegs > 16) begin : g_bad_num_regs
        $error("reg_transfer_seq: NumRegs must be in 2..16");
    end
    if (SettleCycles < 1) begin : g_bad_settle
        $error("reg_transfer_seq: SettleCycles must be at least 1");
    end
    if (DelayRise > 32'hFFFF || DelayFall > 32'hFFFF) begin : g_bad_delay
        $error("reg_transfer_seq: DelayRise/DelayFall out of sensible range");
    end

    typedef enum logic [1:0] {StIdle, StDrive, StLoadHi, StLoadLo} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [SelW-1:0]    src_q, src_d;
    logic [SelW-1:0]    dst_q, dst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [NumRegs-1:0] amb_q, amb_d;
    logic [NumRegs-1:0] load_q, load_d;

    logic req_bad;
    assign req_bad = (32'(bus.src) >= NumRegs) || (32'(bus.dst) >= NumRegs);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        src_d   = bus.src;
                        dst_d   = bus.dst;
                        cnt_d   = CntW'(SettleCycles - 1);
                        state_d = StDrive;
                    end
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    state_d = StLoadHi;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StLoadHi: state_d = StLoadLo;
            StLoadLo: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state so the strobes land in registers.
    always_comb begin
        busy_d = (state_d != StIdle);
        amb_d  = '1;
        load_d = '0;
        for (int i = 0; i < NumRegs; i++) begin
            amb_d[i]  = !(busy_d && (src_d == SelW'(i)));
            load_d[i] = (state_d == StLoadHi) && (dst_d == SelW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            amb_q   <= '1;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            amb_q   <= amb_d;
            load_q  <= load_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.err             = err_q;
    assign bus.assert_main_bar = amb_q;
    assign bus.load            = load_q;
endmodule

// File: tb/tb_reg_transfer_seq.sv
// tb_reg_transfer_seq: checks reg_transfer_seq in three builds:
//   a: NumRegs=4, SettleCycles=1   b: NumRegs=4, SettleCycles=3   c: NumRegs=3, SettleCycles=1
// Expected per-cycle outputs are queued when a request is driven and popped as the DUT runs.
// Build a also feeds a small gpreg model that captures on each falling LOAD bit.
module tb_reg_transfer_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_transfer_if #(.NumRegs(4)) if_a ();
    reg_transfer_if #(.NumRegs(4)) if_b ();
    reg_transfer_if #(.NumRegs(3)) if_c ();

    reg_transfer_seq #(.NumRegs(4), .SettleCycles(1)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    reg_transfer_seq #(.NumRegs(4), .SettleCycles(3)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    reg_transfer_seq #(.NumRegs(3), .SettleCycles(1)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    typedef struct packed {
        logic [3:0] amb;
        logic [3:0] ld;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    typedef struct {
        int which;
        int s;
        int d;
        bit bad;
    } vec_t;

    localparam obs_t Idle = '{amb: 4'hF, ld: 4'h0, busy: 1'b0, done: 1'b0, err: 1'b0};

    obs_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] gp[4];
    logic [3:0] prev_ld = 4'h0;
    vec_t       vecs[8];

    function automatic int settle_of(input int which);
        return (which == 1) ? 3 : 1;
    endfunction

    function automatic obs_t sample(input int which);
        obs_t o;
        case (which)
            0:       o = {if_a.assert_main_bar, if_a.load, if_a.busy, if_a.done, if_a.err};
            1:       o = {if_b.assert_main_bar, if_b.load, if_b.busy, if_b.done, if_b.err};
            default: o = {1'b1, if_c.assert_main_bar, 1'b0, if_c.load,
                          if_c.busy, if_c.done, if_c.err};
        endcase
        return o;
    endfunction

    task automatic set_req(input int which, input logic r, input logic [1:0] s,
                           input logic [1:0] d);
        case (which)
            0: begin if_a.req = r; if_a.src = s; if_a.dst = d; end
            1: begin if_b.req = r; if_b.src = s; if_b.dst = d; end
            default: begin if_c.req = r; if_c.src = s; if_c.dst = d; end
        endcase
    endtask

    task automatic compare(input int which, input obs_t exp, input string tag);
        obs_t got;
        got = sample(which);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got amb=%b load=%b busy=%b done=%b err=%b, want amb=%b load=%b busy=%b done=%b err=%b",
                     tag, which, $time, got.amb, got.ld, got.busy, got.done, got.err,
                     exp.amb, exp.ld, exp.busy, exp.done, exp.err);
        end
        if (which == 0) begin
            // gpreg model: a falling LOAD bit captures whatever single register drives the bus.
            for (int i = 0; i < 4; i++) begin
                if (prev_ld[i] && !got.ld[i]) begin
                    int n = 0;
                    int drv = 0;
                    for (int j = 0; j < 4; j++) begin
                        if (!got.amb[j]) begin
                            n++;
                            drv = j;
                        end
                    end
                    gp[i] = (n == 1) ? gp[drv] : 8'hxx;
                end
            end
            prev_ld = got.ld;
        end
    endtask

    task automatic step(input int which, input string tag);
        obs_t exp;
        @(posedge clk);
        #1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : Idle;
        compare(which, exp, tag);
    endtask

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic push_xfer(input int s, input int d, input int settle);
        logic [3:0] am;
        logic [3:0] lm;
        am = ~(4'b0001 << s);
        lm = 4'b0001 << d;
        for (int c = 0; c < settle; c++) begin
            exp_q.push_back('{amb: am, ld: 4'h0, busy: 1'b1, done: 1'b0, err: 1'b0});
        end
        exp_q.push_back('{amb: am, ld: lm, busy: 1'b1, done: 1'b0, err: 1'b0});
        exp_q.push_back('{amb: am, ld: 4'h0, busy: 1'b1, done: 1'b0, err: 1'b0});
        exp_q.push_back('{amb: 4'hF, ld: 4'h0, busy: 1'b0, done: 1'b1, err: 1'b0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp1;
        logic [7:0] exp2;
        for (int i = 0; i < 4; i++) gp[i] = 8'h11 * (i + 1);
        set_req(0, 1'b0, 2'd0, 2'd0);
        set_req(1, 1'b0, 2'd0, 2'd0);
        set_req(2, 1'b0, 2'd0, 2'd0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        compare(0, Idle, "reset_held");
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) compare(w, Idle, "reset_release");

        // Table of single transfers: {dut, src, dst, rejected}.
        vecs[0] = '{0, 2, 1, 1'b0};
        vecs[1] = '{0, 0, 3, 1'b0};
        vecs[2] = '{0, 1, 1, 1'b0};
        vecs[3] = '{1, 2, 1, 1'b0};
        vecs[4] = '{1, 3, 0, 1'b0};
        vecs[5] = '{2, 3, 0, 1'b1};
        vecs[6] = '{2, 1, 3, 1'b1};
        vecs[7] = '{2, 0, 2, 1'b0};
        foreach (vecs[k]) begin
            int w;
            int n;
            w = vecs[k].which;
            exp1 = gp[vecs[k].s];
            if (vecs[k].bad) begin
                exp_q.push_back('{amb: 4'hF, ld: 4'h0, busy: 1'b0, done: 1'b0, err: 1'b1});
                n = 0;
            end else begin
                push_xfer(vecs[k].s, vecs[k].d, settle_of(w));
                n = settle_of(w) + 2;
            end
            set_req(w, 1'b1, 2'(vecs[k].s), 2'(vecs[k].d));
            step(w, $sformatf("vec%0d", k));
            set_req(w, 1'b0, 2'(vecs[k].s), 2'(vecs[k].d));
            repeat (n) step(w, $sformatf("vec%0d", k));
            step(w, $sformatf("vec%0d_idle", k));
            if (w == 0 && !vecs[k].bad) check_val($sformatf("vec%0d_gp", k), gp[vecs[k].d], exp1);
        end

        // REQ held while busy with new SRC/DST is ignored; still high in DONE -> back-to-back.
        exp1 = gp[2];
        exp2 = gp[0];
        push_xfer(2, 1, 1);
        push_xfer(0, 3, 1);
        set_req(0, 1'b1, 2'd2, 2'd1);
        step(0, "b2b_1");
        set_req(0, 1'b1, 2'd0, 2'd3);
        repeat (4) step(0, "b2b_1");
        set_req(0, 1'b0, 2'd0, 2'd3);
        repeat (3) step(0, "b2b_2");
        step(0, "b2b_idle");
        check_val("b2b_gp1", gp[1], exp1);
        check_val("b2b_gp3", gp[3], exp2);

        // Reset while LOAD is high, then a clean transfer.
        push_xfer(3, 0, 1);
        set_req(0, 1'b1, 2'd3, 2'd0);
        step(0, "rst_mid_drive");
        set_req(0, 1'b0, 2'd3, 2'd0);
        step(0, "rst_mid_loadhi");
        exp_q.delete();
        rst = 1'b1;
        #1;
        compare(0, Idle, "rst_mid_forced");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare(0, Idle, "rst_mid_after");
        exp1 = gp[1];
        push_xfer(1, 2, 1);
        set_req(0, 1'b1, 2'd1, 2'd2);
        step(0, "post_rst");
        set_req(0, 1'b0, 2'd1, 2'd2);
        repeat (3) step(0, "post_rst");
        step(0, "post_rst_idle");
        check_val("post_rst_gp", gp[2], exp1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
